delay_stage_arbiter: RTL and testbench
======================================

DELAY_STAGE_ARBITER -- requirements
Module: delay_stage_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, data width of each requester and of the output stage.
REQ-002 The block SHALL have parameter BURST_LEN, default 4, maximum beats transferred per grant (legal range 1..15).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  2  per-requester beat valid; bit i belongs to requester i.
REQ-006 req_data  input  2xDATA_W  per-requester beat data; slice i belongs to requester i.
REQ-007 req_ready  output  2  per-requester accept; a beat transfers when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-008 out_valid  output  1  output stage holds a valid beat.
REQ-009 out_data  output  DATA_W  registered beat data.
REQ-010 out_src  output  1  index of the requester that supplied out_data.
REQ-011 out_ready  input  1  downstream accept; a beat leaves when out_valid and out_ready are both high.

Function
REQ-012 load SHALL be defined as (!out_valid || out_ready); the stage accepts a new beat only when load is high.
REQ-013 Latency SHALL be exactly one cycle: a beat accepted at edge N appears on out_data/out_src with out_valid high after edge N.
REQ-014 While out_valid && !out_ready, out_data, out_src and out_valid SHALL hold unchanged, and req_ready SHALL be 2'b00.
REQ-015 If load is high and no beat is accepted, out_valid SHALL go low after the edge.
REQ-016 FSM states SHALL be IDLE, OWN0 and OWN1; a 1-bit last_src register and a beat counter beat_cnt SHALL accompany them.
REQ-017 In IDLE with one request valid, that requester SHALL be selected; with both valid, requester !last_src SHALL be selected.
REQ-018 In IDLE, req_ready of the selected requester SHALL equal load; all other ready bits SHALL be low.
REQ-019 On a transfer from IDLE, the FSM SHALL move to OWNi, with beat_cnt=1 and last_src=i.
REQ-020 In OWNi, only req_ready[i] SHALL be asserted (equal to load); the other requester SHALL never be granted.
REQ-021 In OWNi, each transfer SHALL increment beat_cnt; a transfer that makes beat_cnt equal BURST_LEN SHALL return the FSM to IDLE with beat_cnt=0.
REQ-022 In OWNi, if req_valid[i] is low, the FSM SHALL return to IDLE at the next edge (burst released early) with beat_cnt=0.
REQ-023 If BURST_LEN=1, every transfer SHALL return to IDLE.
REQ-024 On return to IDLE, one bubble cycle before the next grant is permitted; zero-bubble handover is not required.
REQ-025 req_ready SHALL be independent of out_data and of req_data (no combinational data-to-ready path).

Reset
REQ-026 While n_rst is low, the block SHALL hold out_valid=0, out_data=0, out_src=0, state=IDLE, beat_cnt=0 and last_src=1, so that requester 0 wins the first contended arbitration.
REQ-027 Reset asserted mid-burst or with a stalled output SHALL discard the held beat and the burst with no partial transfer after reset release.
REQ-028 req_ready SHALL be 2'b00 while n_rst is low.

Structure
REQ-029 The FSM state enum (IDLE, OWN0, OWN1) and the BURST_LEN default SHALL reside in a shared package, delay_arb_pkg.
REQ-030 The output register with load enable SHALL be a sub-module, delay_stage_en (DATA_W data plus 1-bit src, async active-low clear).

Verification
REQ-031 Single requester: requester 0 sends 0x11111111 and 0x22222222 with out_ready=1 -> the beats appear one cycle after each accept, out_src=0.
REQ-032 Contention from reset: both valid, BURST_LEN=4, out_ready=1 -> requester 0 gets 4 beats, then one bubble, then requester 1 gets 4 beats, alternating thereafter.
REQ-033 Backpressure: requester 1 sends 0xDEADBEEF while out_ready=0 for 3 cycles -> out_data holds 0xDEADBEEF, req_ready=00, and the next beat is accepted in the cycle out_ready rises.
REQ-034 Early release: requester 0 drops valid after 2 beats while requester 1 is valid -> IDLE, then grant to requester 1, last_src=1.
REQ-035 Reset mid-burst: n_rst pulsed low during OWN1 with out_valid=1 -> out_valid=0 immediately, state IDLE, and the next contended grant goes to requester 0.

Source files
------------

// File: rtl/delay_arb_pkg.sv
// Shared definitions for the delay-stage arbiter.
//   arb_state_t        : arbitration FSM states (IDLE, OWN0, OWN1)
//   BURST_LEN_DEFAULT  : default maximum beats per grant
package delay_arb_pkg;

  localparam int BURST_LEN_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/delay_stage_en.sv
// Output register with load enable: captures beat data and its source index.
//   clk    : clock
//   n_rst  : asynchronous active-low clear
//   en     : load enable
//   d_data : DATA_W beat data to capture
//   d_src  : source index to capture
//   q_data : registered data
//   q_src  : registered source index
module delay_stage_en #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              en,
  input  logic [DATA_W-1:0] d_data,
  input  logic              d_src,
  output logic [DATA_W-1:0] q_data,
  output logic              q_src
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      q_data <= '0;
      q_src  <= 1'b0;
    end else if (en) begin
      q_data <= d_data;
      q_src  <= d_src;
    end
  end

endmodule

// File: rtl/delay_stage_arbiter.sv
// Two-requester burst arbiter feeding a single registered output stage.
//   clk       : clock
//   n_rst     : asynchronous active-low reset
//   req_valid : per-requester beat valid
//   req_data  : per-requester beat data (slice i = requester i)
//   req_ready : per-requester accept
//   out_valid : output stage holds a valid beat
//   out_data  : registered beat data
//   out_src   : requester that supplied out_data
//   out_ready : downstream accept
// A requester keeps ownership for up to BURST_LEN beats or until it drops
// valid. After a full burst the arbiter idles one cycle before re-granting.
module delay_stage_arbiter
  import delay_arb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = BURST_LEN_DEFAULT
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [1:0]          req_valid,
  input  logic [2*DATA_W-1:0] req_data,
  output logic [1:0]          req_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_src,
  input  logic                out_ready
);

  localparam logic [3:0] LAST_CNT = 4'(BURST_LEN - 1);

  arb_state_t  state_reg;
  logic [3:0]  beat_cnt_reg;
  logic        last_src_reg;
  logic        bubble_reg;     // one idle cycle after a completed burst
  logic        out_valid_reg;

  logic              load;
  logic              idle_sel;
  logic [1:0]        grant;
  logic [1:0]        xfer;
  logic              xfer_any;
  logic              xfer_src;
  logic              owner;
  logic [DATA_W-1:0] req_data_arr [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_split
      assign req_data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign load = !out_valid_reg || out_ready;

  // Sole requester wins; on contention the one not served last wins.
  assign idle_sel = (&req_valid) ? ~last_src_reg : req_valid[1];

  always_comb begin
    grant = 2'b00;
    case (state_reg)
      IDLE:    if (!bubble_reg) grant[idle_sel] = 1'b1;
      OWN0:    grant[0] = 1'b1;
      OWN1:    grant[1] = 1'b1;
      default: grant = 2'b00;
    endcase
  end

  // Ready depends only on state, valid, out_valid and out_ready; the reset
  // term keeps both ready bits low for the whole time reset is held.
  assign req_ready = n_rst ? (grant & {2{load}}) : 2'b00;
  assign xfer      = req_ready & req_valid;
  assign xfer_any  = |xfer;
  assign xfer_src  = xfer[1];
  assign owner     = (state_reg == OWN1);

  delay_stage_en #(.DATA_W(DATA_W)) u_stage (
    .clk    (clk),
    .n_rst  (n_rst),
    .en     (xfer_any),
    .d_data (req_data_arr[xfer_src]),
    .d_src  (xfer_src),
    .q_data (out_data),
    .q_src  (out_src)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_valid_reg <= 1'b0;
    end else if (load) begin
      out_valid_reg <= xfer_any;
    end
  end

  assign out_valid = out_valid_reg;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg    <= IDLE;
      beat_cnt_reg <= 4'd0;
      last_src_reg <= 1'b1;
      bubble_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          bubble_reg <= 1'b0;
          if (xfer_any) begin
            last_src_reg <= xfer_src;
            if (BURST_LEN == 1) begin
              bubble_reg <= 1'b1;
            end else begin
              state_reg    <= xfer_src ? OWN1 : OWN0;
              beat_cnt_reg <= 4'd1;
            end
          end
        end
        OWN0, OWN1: begin
          if (xfer_any) begin
            if (beat_cnt_reg == LAST_CNT) begin
              state_reg    <= IDLE;
              beat_cnt_reg <= 4'd0;
              bubble_reg   <= 1'b1;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 4'd1;
            end
          end else if (!req_valid[owner]) begin
            // Owner went quiet: release the burst early.
            state_reg    <= IDLE;
            beat_cnt_reg <= 4'd0;
          end
        end
        default: begin
          state_reg    <= IDLE;
          beat_cnt_reg <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_stage_arbiter.sv
module tb_delay_stage_arbiter;

  localparam int DW = 32;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [1:0]    req_valid = 2'b00;
  logic [2*DW-1:0] req_data = '0;
  logic [1:0]    req_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_src;
  logic          out_ready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  delay_stage_arbiter #(.DATA_W(DW), .BURST_LEN(BL)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Tracks who owns the link, how many beats it has moved, and whether
  // the arbiter is resting after a completed burst.
  logic          m_ov;
  logic [DW-1:0] m_od;
  logic          m_os;
  int            m_owner;   // -1 = nobody
  int            m_cnt;
  logic          m_last;
  logic          m_rest;

  task automatic model_reset();
    m_ov = 0; m_od = '0; m_os = 0;
    m_owner = -1; m_cnt = 0; m_last = 1; m_rest = 0;
  endtask

  function automatic logic [1:0] model_ready(input logic [1:0] v, input logic ordy);
    logic [1:0] r;
    bit can_load;
    int pick;
    r = 2'b00;
    can_load = !m_ov || ordy;
    if (m_owner >= 0) begin
      r[m_owner] = can_load;
    end else if (!m_rest) begin
      if (v == 2'b11) pick = m_last ? 0 : 1;
      else if (v == 2'b10) pick = 1;
      else pick = 0;
      r[pick] = can_load;
    end
    return r;
  endfunction

  task automatic model_step(input logic [1:0] v, input logic [DW-1:0] d0,
                            input logic [DW-1:0] d1, input logic ordy);
    logic [1:0] x;
    int who;
    x = model_ready(v, ordy) & v;
    who = x[1] ? 1 : 0;
    if (x != 2'b00) begin
      m_ov = 1; m_os = x[1]; m_od = x[1] ? d1 : d0;
    end else if (!m_ov || ordy) begin
      m_ov = 0;
    end
    if (m_owner >= 0) begin
      if (x != 2'b00) begin
        m_cnt++;
        if (m_cnt == BL) begin m_owner = -1; m_cnt = 0; m_rest = 1; end
      end else if (!v[m_owner]) begin
        m_owner = -1; m_cnt = 0;
      end
    end else begin
      m_rest = 0;
      if (x != 2'b00) begin
        m_last = x[1];
        if (BL == 1) m_rest = 1;
        else begin m_owner = who; m_cnt = 1; end
      end
    end
  endtask

  // ---------------- drivers ----------------
  // All drivers start and end at a falling edge.
  task automatic do_reset();
    n_rst = 0; req_valid = 2'b00; out_ready = 0;
    #1;
    chk("rst_ready", 64'(req_ready), 64'(2'b00));
    chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_src", 64'(out_src), 64'(1'b0));
    @(negedge clk);
    @(negedge clk);
    n_rst = 1;
    model_reset();
  endtask

  task automatic drive_chk(input string name, input logic [1:0] v, input logic [DW-1:0] d0,
                           input logic [DW-1:0] d1, input logic ordy, input logic [1:0] er,
                           input logic eov, input logic [DW-1:0] ed, input logic es);
    req_valid = v; req_data = {d1, d0}; out_ready = ordy;
    #1;
    chk({name, "_ready"}, 64'(req_ready), 64'(er));
    @(posedge clk);
    #1;
    chk({name, "_out_valid"}, 64'(out_valid), 64'(eov));
    chk({name, "_out_data"}, 64'(out_data), 64'(ed));
    chk({name, "_out_src"}, 64'(out_src), 64'(es));
    $display("  %s v=%b ordy=%b ready=%b out_valid=%b out_data=%h out_src=%b",
             name, v, ordy, req_ready, out_valid, out_data, out_src);
    @(negedge clk);
  endtask

  task automatic model_cycle(input logic [1:0] v, input logic [DW-1:0] d0,
                             input logic [DW-1:0] d1, input logic ordy);
    logic [1:0] er;
    er = model_ready(v, ordy);
    model_step(v, d0, d1, ordy);
    drive_chk("rnd", v, d0, d1, ordy, er, m_ov, m_od, m_os);
  endtask

  typedef struct {
    bit            rst;
    logic [1:0]    v;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic          ordy;
    logic [1:0]    er;
    logic          eov;
    logic [DW-1:0] ed;
    logic          es;
  } vec_t;

  vec_t tbl [16];

  localparam logic [DW-1:0] A = 32'hA0A0A0A0;
  localparam logic [DW-1:0] B = 32'hB1B1B1B1;

  initial begin
    // single requester
    tbl[0]  = '{1, 2'b01, 32'h11111111, 0, 1, 2'b01, 1, 32'h11111111, 0};
    tbl[1]  = '{0, 2'b01, 32'h22222222, 0, 1, 2'b01, 1, 32'h22222222, 0};
    tbl[2]  = '{0, 2'b00, 0, 0, 1, 2'b01, 0, 32'h22222222, 0};
    // contention from reset: 4 beats r0, bubble, 4 beats r1, bubble, r0
    tbl[3]  = '{1, 2'b11, A, B, 1, 2'b01, 1, A, 0};
    tbl[4]  = '{0, 2'b11, A, B, 1, 2'b01, 1, A, 0};
    tbl[5]  = '{0, 2'b11, A, B, 1, 2'b01, 1, A, 0};
    tbl[6]  = '{0, 2'b11, A, B, 1, 2'b01, 1, A, 0};
    tbl[7]  = '{0, 2'b11, A, B, 1, 2'b00, 0, A, 0};
    tbl[8]  = '{0, 2'b11, A, B, 1, 2'b10, 1, B, 1};
    tbl[9]  = '{0, 2'b11, A, B, 1, 2'b10, 1, B, 1};
    tbl[10] = '{0, 2'b11, A, B, 1, 2'b10, 1, B, 1};
    tbl[11] = '{0, 2'b11, A, B, 1, 2'b10, 1, B, 1};
    tbl[12] = '{0, 2'b11, A, B, 1, 2'b00, 0, B, 1};
    tbl[13] = '{0, 2'b11, A, B, 1, 2'b01, 1, A, 0};
    tbl[14] = '{0, 2'b11, A, B, 1, 2'b01, 1, A, 0};
    tbl[15] = '{0, 2'b01, A, B, 0, 2'b00, 1, A, 0};

    model_reset();
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].rst) do_reset();
      drive_chk($sformatf("tbl%0d", i), tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].ordy,
                tbl[i].er, tbl[i].eov, tbl[i].ed, tbl[i].es);
    end

    // backpressure: held beat, ready low, next beat in the cycle ready rises
    do_reset();
    drive_chk("bp0", 2'b10, 0, 32'hDEADBEEF, 1, 2'b10, 1, 32'hDEADBEEF, 1);
    for (int i = 0; i < 3; i++)
      drive_chk("bp_stall", 2'b10, 0, 32'h12345678, 0, 2'b00, 1, 32'hDEADBEEF, 1);
    drive_chk("bp_resume", 2'b10, 0, 32'h12345678, 1, 2'b10, 1, 32'h12345678, 1);

    // early release, then last_src=1 shows as requester 0 winning contention
    do_reset();
    drive_chk("er0", 2'b01, 32'h0E0E0E0E, 32'h1E1E1E1E, 1, 2'b01, 1, 32'h0E0E0E0E, 0);
    drive_chk("er1", 2'b11, 32'h0E0E0E0E, 32'h1E1E1E1E, 1, 2'b01, 1, 32'h0E0E0E0E, 0);
    drive_chk("er2", 2'b10, 32'h0E0E0E0E, 32'h1E1E1E1E, 1, 2'b01, 0, 32'h0E0E0E0E, 0);
    drive_chk("er3", 2'b10, 32'h0E0E0E0E, 32'h1E1E1E1E, 1, 2'b10, 1, 32'h1E1E1E1E, 1);
    drive_chk("er4", 2'b00, 32'h0E0E0E0E, 32'h1E1E1E1E, 1, 2'b10, 0, 32'h1E1E1E1E, 1);
    drive_chk("er5", 2'b11, 32'h0F0F0F0F, 32'h1E1E1E1E, 1, 2'b01, 1, 32'h0F0F0F0F, 0);

    // reset mid-burst with a stalled output
    do_reset();
    drive_chk("mr0", 2'b10, 0, 32'hCAFEF00D, 1, 2'b10, 1, 32'hCAFEF00D, 1);
    drive_chk("mr1", 2'b10, 0, 32'h55555555, 0, 2'b00, 1, 32'hCAFEF00D, 1);
    n_rst = 0;
    #1;
    chk("mr_rst_out_valid", 64'(out_valid), 64'(1'b0));
    chk("mr_rst_ready", 64'(req_ready), 64'(2'b00));
    @(negedge clk);
    n_rst = 1;
    model_reset();
    drive_chk("mr2", 2'b11, 32'h77777777, 32'h88888888, 1, 2'b01, 1, 32'h77777777, 0);

    // randomized run against the model, with occasional async resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        n_rst = 0;
        #1;
        chk("rnd_rst_out_valid", 64'(out_valid), 64'(1'b0));
        chk("rnd_rst_ready", 64'(req_ready), 64'(2'b00));
        @(negedge clk);
        n_rst = 1;
        model_reset();
      end else begin
        logic [1:0] v;
        logic ordy;
        v = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) :
            ($urandom_range(0, 1) ? 2'b11 : 2'($urandom_range(1, 2)));
        ordy = ($urandom_range(0, 3) != 0);
        model_cycle(v, $urandom, $urandom, ordy);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
